fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the ID-stage hazard/stall logic and is driven by its outputs.
- Owns the PC register, next-PC selection (sequential / branch / jump), the instruction-memory address, and the IF/ID pipeline register with hold and flush.
- Also keeps saturating stall and flush event counters and a sticky misaligned-target flag for debug.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its neighbours (decode, hazard).
//   - instruction-word typedef and IF/ID payload struct
//   - reset defaults for PC and the bubble instruction
//   - primary opcodes for j / beq / bne
package fetch_stage_pkg;
    typedef logic [31:0] instr_t;

    localparam instr_t      NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    typedef struct packed {
        instr_t      instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with hold/flush priority (hold beats flush).
//   clk, rst_n     : clock, async active-low reset
//   hold_i         : keep all fields
//   flush_i        : load a bubble (NOP, valid=0) but still track pc_plus4
//   instr_i        : fetched instruction word
//   pc_plus4_i     : PC+4 of the fetched word
//   q_o            : registered IF/ID payload
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter instr_t NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        flush_i,
    input  instr_t      instr_i,
    input  logic [31:0] pc_plus4_i,
    output if_id_t      q_o
);
    if_id_t q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q.instr    <= NOP_INSTR;
            q_q.pc_plus4 <= 32'h0;
            q_q.valid    <= 1'b0;
        end else if (hold_i) begin
            q_q <= q_q;
        end else if (flush_i) begin
            q_q.instr    <= NOP_INSTR;
            q_q.pc_plus4 <= pc_plus4_i;
            q_q.valid    <= 1'b0;
        end else begin
            q_q.instr    <= instr_i;
            q_q.pc_plus4 <= pc_plus4_i;
            q_q.valid    <= 1'b1;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register,
// saturating stall/flush counters and a sticky misaligned-target flag.
//   pc_hold, if_id_hold, if_flush      : hazard-unit controls
//   jump, branch_taken, branch_target  : ID-stage redirects (branch wins)
//   imem_addr / imem_rdata             : combinational instruction memory port
//   pc, if_id_*                        : registered stage state
//   stall_cnt, flush_cnt, misalign_err : debug observability
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter instr_t      NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_hold,
    input  logic             if_id_hold,
    input  logic             if_flush,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             misalign_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d, pc_plus4, jump_target;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             misalign_q;
    logic             take_branch, flush_eff;
    if_id_t           if_id;

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {if_id.pc_plus4[31:28], if_id.instr[25:0], 2'b00};

    // Hold swallows any redirect; the hazard unit must re-issue it.
    assign take_branch = !pc_hold && branch_taken;
    assign flush_eff   = if_flush && !if_id_hold;

    always_comb begin
        pc_d = pc_plus4;
        if (pc_hold)           pc_d = pc_q;
        else if (branch_taken) pc_d = {branch_target[31:2], 2'b00};
        else if (jump)         pc_d = jump_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (pc_hold && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_eff && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            if (take_branch && branch_target[1:0] != 2'b00)
                misalign_q <= 1'b1;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_i     (if_id_hold),
        .flush_i    (if_flush),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_plus4),
        .q_o        (if_id)
    );

    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign if_id_instr    = if_id.instr;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;
    assign misalign_err   = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_hold, if_id_hold, if_flush, jump, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid, misalign_err;
    logic [15:0] stall_cnt, flush_cnt;

    // second instance with narrow counters, driven by the same stimulus
    logic [31:0] s_imem_addr, s_imem_rdata, s_pc, s_instr, s_pc4;
    logic        s_valid, s_mis;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic        ovr_en;
    logic [31:0] ovr_word;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // memory returns its address as data unless overridden
    assign imem_rdata   = ovr_en ? ovr_word : imem_addr;
    assign s_imem_rdata = ovr_en ? ovr_word : s_imem_addr;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .if_flush(if_flush), .jump(jump), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid(if_id_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .misalign_err(misalign_err)
    );

    fetch_stage #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .if_flush(if_flush), .jump(jump), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
        .pc(s_pc), .if_id_instr(s_instr), .if_id_pc_plus4(s_pc4),
        .if_id_valid(s_valid), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .misalign_err(s_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        pc_hold = 0; if_id_hold = 0; if_flush = 0; jump = 0; branch_taken = 0;
        branch_target = 32'h0; ovr_en = 0; ovr_word = 32'h0;
    endtask

    task automatic test_reset();
        clear_ctl();
        rst_n = 0;
        repeat (3) tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp %h", if_id_instr, 32'h0); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp %h", if_id_pc_plus4, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_id_valid); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_mis got %b exp 0", misalign_err); end
        rst_n = 1;
    endtask

    task automatic test_seq_fetch();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0 got %h exp %h", imem_addr, 32'h0); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got %h exp %h", pc, 32'h4); end
        checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_ifid1 got %h/%b exp 0/1", if_id_instr, if_id_valid); end
        tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2 got %h exp %h", pc, 32'h8); end
        checks++; if (if_id_instr !== 32'h4 || if_id_pc_plus4 !== 32'h8) begin errors++; $display("FAIL seq_ifid2 got %h/%h exp 4/8", if_id_instr, if_id_pc_plus4); end
        tick();
        checks++; if (pc !== 32'hC || imem_addr !== 32'hC) begin errors++; $display("FAIL seq_pc3 got %h/%h exp c/c", pc, imem_addr); end
        checks++; if (if_id_instr !== 32'h8) begin errors++; $display("FAIL seq_ifid3 got %h exp 8", if_id_instr); end
    endtask

    task automatic test_load_use_stall();
        tick(); // pc = 0x10, IF/ID = word@0xC
        pc_hold = 1; if_id_hold = 1;
        tick(); tick();
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc got %h exp 10", pc); end
        checks++; if (if_id_instr !== 32'hC || if_id_pc_plus4 !== 32'h10 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid got %h/%h/%b exp c/10/1", if_id_instr, if_id_pc_plus4, if_id_valid); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", stall_cnt); end
        clear_ctl();
        tick();
        checks++; if (pc !== 32'h14 || if_id_instr !== 32'h10) begin errors++; $display("FAIL stall_resume got %h/%h exp 14/10", pc, if_id_instr); end
    endtask

    task automatic test_branch_flush();
        tick(); tick(); tick(); // pc = 0x20
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL br_pre got %h exp 20", pc); end
        branch_taken = 1; branch_target = 32'h100; if_flush = 1;
        tick();
        clear_ctl();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got %h exp 100", pc); end
        checks++; if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h24) begin errors++; $display("FAIL br_bubble got %h/%b/%h exp 0/0/24", if_id_instr, if_id_valid, if_id_pc_plus4); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", flush_cnt); end
        tick();
        checks++; if (if_id_instr !== 32'h100 || if_id_valid !== 1'b1 || pc !== 32'h104) begin errors++; $display("FAIL br_next got %h/%b/%h exp 100/1/104", if_id_instr, if_id_valid, pc); end
    endtask

    task automatic test_jump();
        branch_taken = 1; branch_target = 32'h3000_0000;
        tick();
        clear_ctl();
        ovr_en = 1; ovr_word = 32'h0800_0040;
        tick();
        ovr_en = 0;
        checks++; if (if_id_instr !== 32'h0800_0040 || if_id_pc_plus4 !== 32'h3000_0004) begin errors++; $display("FAIL j_setup got %h/%h exp 08000040/30000004", if_id_instr, if_id_pc_plus4); end
        jump = 1;
        tick();
        checks++; if (pc !== 32'h3000_0100) begin errors++; $display("FAIL j_pc got %h exp 30000100", pc); end
        // IF/ID now holds 0x30000004 -> a jump would go to 0x30000010
        branch_taken = 1; branch_target = 32'h200;
        tick();
        clear_ctl();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL j_vs_br got %h exp 200", pc); end
    endtask

    task automatic test_hold_vs_flush();
        // IF/ID holds word@0x30000100, pc4 0x30000104; stall_cnt 2, flush_cnt 1
        pc_hold = 1; if_id_hold = 1; if_flush = 1; branch_taken = 1; branch_target = 32'h300;
        tick();
        clear_ctl();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL hold_pc got %h exp 200", pc); end
        checks++; if (if_id_instr !== 32'h3000_0100 || if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h3000_0104) begin errors++; $display("FAIL hold_ifid got %h/%b/%h exp 30000100/1/30000104", if_id_instr, if_id_valid, if_id_pc_plus4); end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin errors++; $display("FAIL hold_cnt got %0d/%0d exp 1/3", flush_cnt, stall_cnt); end
    endtask

    task automatic test_boundaries();
        branch_taken = 1; branch_target = 32'hFFFF_FFFC;
        tick();
        clear_ctl();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got %h exp fffffffc", pc); end
        tick();
        checks++; if (pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap got %h/%h exp 0/0", pc, if_id_pc_plus4); end
        branch_taken = 1; branch_target = 32'h102;
        tick();
        clear_ctl();
        checks++; if (pc !== 32'h100 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got %h/%b exp 100/1", pc, misalign_err); end
        tick();
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", misalign_err); end
        pc_hold = 1;
        repeat (20) tick();
        checks++; if (stall_cnt !== 16'd23) begin errors++; $display("FAIL stall_wide got %0d exp 23", stall_cnt); end
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d exp 15", s_stall_cnt); end
        // asynchronous reset between edges
        #2 rst_n = 0;
        #1;
        checks++; if (pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL arst_state got %h/%b/%h exp 0/0/0", pc, if_id_valid, if_id_pc_plus4); end
        checks++; if (misalign_err !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin errors++; $display("FAIL arst_dbg got %b/%0d/%0d/%0d exp 0/0/0/0", misalign_err, stall_cnt, flush_cnt, s_stall_cnt); end
        clear_ctl();
        tick();
        rst_n = 1;
        tick();
        checks++; if (pc !== 32'h4 || if_id_instr !== 32'h0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL arst_resume got %h/%h/%b exp 4/0/1", pc, if_id_instr, if_id_valid); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_load_use_stall();
        test_branch_flush();
        test_jump();
        test_hold_vs_flush();
        test_boundaries();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
